cache_controller: RTL and testbench

//  Initiator side of the 2-way data cache: takes MEM-stage load/store requests, drives the cache

---
 rtl/cache_controller_pkg.sv | 8 +
 rtl/cache_addr_map.sv | 17 +
 rtl/cache_controller.sv | 96 +++++++++
 tb/tb_cache_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_controller_pkg.sv
// cache_controller_pkg: shared FSM state type and geometry constants for the data-cache controller
package cache_controller_pkg;
    typedef enum logic [1:0] {IDLE, MISS, WRITE} state_t;
    localparam logic [31:0] BASE_ADDR = 32'd1024;
    localparam int AW     = 17;
    localparam int LINE_W = 64;
    localparam int WORD_W = 32;
endpackage

// File: rtl/cache_addr_map.sv
// cache_addr_map: pipeline byte address -> cache word address, line-aligned SRAM address, word select
//   address   in   32  byte address from the pipeline
//   word_addr out  AW  (address - BASE_ADDR) >> 2, low AW bits; addresses below the base wrap
//   line_addr out  32  address with bits [2:0] cleared
//   word_sel  out  1   selects the odd word of a 64-bit line
module cache_addr_map
    import cache_controller_pkg::*;
(
    input  logic [31:0]   address,
    output logic [AW-1:0] word_addr,
    output logic [31:0]   line_addr,
    output logic          word_sel
);
    assign word_addr = AW'((address - BASE_ADDR) >> 2);
    assign line_addr = {address[31:3], 3'b000};
    assign word_sel  = address[2];
endmodule

// File: rtl/cache_controller.sv
// cache_controller: write-through, no-allocate initiator for the 2-way data cache and the SRAM controller
//   clk, rst                     clock; asynchronous active-high reset
//   mem_r_en, mem_w_en           load / store request, held until ready
//   address, wdata               pipeline byte address and store data
//   rdata, ready                 load data and completion (0 stalls the pipeline)
//   cache_address, cache_wdata   cache word address and fill line {odd, even}
//   cache_read_en                lookup strobe
//   cache_write_en               one-cycle line fill
//   cache_invoke                 invalidate-on-hit strobe for stores
//   cache_rdata, cache_hit       cache lookup result
//   sram_address, sram_wdata     SRAM byte address and store word
//   sram_read_en, sram_write_en  line read / word write requests, held until sram_ready
//   sram_rdata, sram_ready       SRAM line data and completion
module cache_controller
    import cache_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [31:0]       address,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic [AW-1:0]     cache_address,
    output logic [LINE_W-1:0] cache_wdata,
    output logic              cache_read_en,
    output logic              cache_write_en,
    output logic              cache_invoke,
    input  logic [WORD_W-1:0] cache_rdata,
    input  logic              cache_hit,
    output logic [31:0]       sram_address,
    output logic [WORD_W-1:0] sram_wdata,
    output logic              sram_read_en,
    output logic              sram_write_en,
    input  logic [LINE_W-1:0] sram_rdata,
    input  logic              sram_ready
);
    state_t      state, next_state;
    logic [31:0] line_addr;
    logic        word_sel;

    cache_addr_map u_map (
        .address   (address),
        .word_addr (cache_address),
        .line_addr (line_addr),
        .word_sel  (word_sel)
    );

    assign cache_wdata = sram_rdata;
    assign sram_wdata  = wdata;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next_state;

    // Outputs are decoded from the state register, so an asynchronous reset
    // drops the SRAM enables immediately.
    always_comb begin
        next_state     = state;
        ready          = 1'b1;
        rdata          = cache_rdata;
        cache_read_en  = 1'b0;
        cache_write_en = 1'b0;
        cache_invoke   = 1'b0;
        sram_read_en   = 1'b0;
        sram_write_en  = 1'b0;
        sram_address   = address;
        unique case (state)
            IDLE:
                if (mem_w_en) begin
                    cache_invoke = 1'b1;
                    ready        = 1'b0;
                    next_state   = WRITE;
                end else if (mem_r_en) begin
                    cache_read_en = 1'b1;
                    ready         = cache_hit;
                    next_state    = cache_hit ? IDLE : MISS;
                end
            MISS: begin
                sram_read_en   = 1'b1;
                sram_address   = line_addr;
                ready          = sram_ready;
                cache_write_en = sram_ready;
                rdata          = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
                next_state     = sram_ready ? IDLE : MISS;
            end
            WRITE: begin
                sram_write_en = 1'b1;
                ready         = sram_ready;
                next_state    = sram_ready ? IDLE : WRITE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed scoreboard bench with a behavioural 2-way LRU cache and SRAM model
module tb_cache_controller;
    logic        clk, rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] address, wdata, rdata;
    logic        ready;
    logic [16:0] cache_address;
    logic [63:0] cache_wdata;
    logic        cache_read_en, cache_write_en, cache_invoke;
    logic [31:0] cache_rdata;
    logic        cache_hit;
    logic [31:0] sram_address, sram_wdata;
    logic        sram_read_en, sram_write_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    cache_controller dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .cache_address(cache_address), .cache_wdata(cache_wdata),
        .cache_read_en(cache_read_en), .cache_write_en(cache_write_en),
        .cache_invoke(cache_invoke), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- SRAM model: ready in the lat-th cycle of a held request
    logic        tb_init = 1'b1;
    int          lat = 3;
    int          scnt = 0;
    logic [31:0] smem [1024];

    function automatic logic [31:0] init_val(input int i);
        return i == 256 ? 32'h0000_AAAA : i == 257 ? 32'h0000_BBBB : 32'hD000_0000 | 32'(i);
    endfunction

    assign sram_ready = (sram_read_en | sram_write_en) && scnt == lat - 1;
    assign sram_rdata = {smem[{sram_address[11:3], 1'b1}], smem[{sram_address[11:3], 1'b0}]};

    always @(posedge clk) begin
        scnt <= ((sram_read_en | sram_write_en) && !sram_ready) ? scnt + 1 : 0;
        if (tb_init) for (int i = 0; i < 1024; i++) smem[i] <= init_val(i);
        else if (sram_write_en && sram_ready) smem[sram_address[11:2]] <= sram_wdata;
    end

    // ---------------- cache model: 64 sets x 2 ways, LRU, invalidate on invoke&hit
    logic [1:0]  cval [64];
    logic        clru [64];
    logic [9:0]  ctag [64][2];
    logic [63:0] cdat [64][2];
    logic [5:0]  ci;
    logic [9:0]  ct;
    logic        h0, h1, vic;

    always_comb begin
        ci = cache_address[6:1];
        ct = cache_address[16:7];
        h0 = cval[ci][0] && ctag[ci][0] == ct;
        h1 = cval[ci][1] && ctag[ci][1] == ct;
        cache_hit = h0 | h1;
        cache_rdata = h1 ? (cache_address[0] ? cdat[ci][1][63:32] : cdat[ci][1][31:0])
                         : (cache_address[0] ? cdat[ci][0][63:32] : cdat[ci][0][31:0]);
        vic = !cval[ci][0] ? 1'b0 : !cval[ci][1] ? 1'b1 : clru[ci];
    end

    always @(posedge clk) begin
        if (tb_init) begin
            for (int s = 0; s < 64; s++) begin
                cval[s] <= 2'b00;
                clru[s] <= 1'b0;
            end
        end else begin
            if (cache_write_en) begin
                ctag[ci][vic] <= ct;
                cdat[ci][vic] <= cache_wdata;
                cval[ci][vic] <= 1'b1;
                clru[ci]      <= ~vic;
            end
            if (cache_read_en && cache_hit) clru[ci] <= ~h1;
            if (cache_invoke && cache_hit) cval[ci][h1] <= 1'b0;
        end
    end

    // ---------------- scoreboard
    typedef struct { bit load; logic [31:0] data; } exp_t;
    exp_t sbq[$];

    always begin
        @(negedge clk);
        #2;
        if (!rst && ready && (mem_r_en || mem_w_en)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got 1 expected 0");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("req_kind", 32'(mem_r_en & ~mem_w_en), 32'(e.load));
                if (e.load) chk("rdata", rdata, e.data);
            end
        end
    end

    always begin
        @(negedge clk);
        #3;
        if (!rst) chk("rd_wr_exclusive", 32'(cache_read_en & cache_write_en), 32'd0);
    end

    // ---------------- stimulus
    int stalls, fills, inv, srd, swr, cre;

    task automatic do_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] e);
        exp_t x;
        bit   done;
        mem_r_en = r;
        mem_w_en = w;
        address  = a;
        wdata    = d;
        x.load   = r & ~w;
        x.data   = e;
        sbq.push_back(x);
        stalls = 0; fills = 0; inv = 0; srd = 0; swr = 0; cre = 0;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            fills  += int'(cache_write_en);
            inv    += int'(cache_invoke);
            srd    += int'(sram_read_en);
            swr    += int'(sram_write_en);
            cre    += int'(cache_read_en);
            if (ready) done = 1;
            else stalls++;
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout addr=%h: got no ready expected ready", a);
            void'(sbq.pop_back());
        end
        mem_r_en = 0;
        mem_w_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; mem_r_en = 0; mem_w_en = 0; address = 0; wdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_sram_en", 32'({sram_read_en, sram_write_en}), 32'd0);
        chk("rst_cache_en", 32'({cache_read_en, cache_write_en, cache_invoke}), 32'd0);
        @(negedge clk);
        rst = 0;
        tb_init = 0;
        @(negedge clk);
        // 1: load miss
        do_req(1, 0, 32'h400, 0, 32'h0000_AAAA);
        chk("t1_stalls", stalls, 3);
        chk("t1_fills", fills, 1);
        // 2: load hit in same line
        do_req(1, 0, 32'h404, 0, 32'h0000_BBBB);
        chk("t2_stalls", stalls, 0);
        chk("t2_sram_rd", srd, 0);
        // 3: store then reload misses
        do_req(0, 1, 32'h400, 32'h1234_5678, 0);
        chk("t3_invoke", inv, 1);
        chk("t3_sram_wr", swr, 3);
        chk("t3_stalls", stalls, 3);
        do_req(1, 0, 32'h400, 0, 32'h1234_5678);
        chk("t3_reload_miss", 32'(srd > 0), 32'd1);
        chk("t3_reload_stalls", stalls, 3);
        // 5: both enables -> store
        do_req(1, 1, 32'h400, 32'hCAFE_F00D, 0);
        chk("t5_read_en", cre, 0);
        chk("t5_invoke", inv, 1);
        chk("t5_sram_wr", swr, 3);
        // 4: set thrash on index 0
        do_req(1, 0, 32'h400, 0, 32'hCAFE_F00D);
        chk("t4_miss_400", 32'(srd > 0), 32'd1);
        do_req(1, 0, 32'h600, 0, 32'hD000_0180);
        chk("t4_miss_600", 32'(srd > 0), 32'd1);
        do_req(1, 0, 32'h800, 0, 32'hD000_0200);
        chk("t4_miss_800", 32'(srd > 0), 32'd1);
        do_req(1, 0, 32'h400, 0, 32'hCAFE_F00D);
        chk("t4_remiss_400", 32'(srd > 0), 32'd1);
        do_req(1, 0, 32'h800, 0, 32'hD000_0200);
        chk("t4_hit_800", stalls, 0);
        // 6: reset in the 2nd MISS cycle
        lat = 5;
        mem_r_en = 1;
        address  = 32'hC00;
        #1;
        chk("t6_lookup", 32'(cache_read_en), 32'd1);
        chk("t6_miss_ready", 32'(ready), 32'd0);
        @(negedge clk);
        #1;
        chk("t6_sram_rd", 32'(sram_read_en), 32'd1);
        chk("t6_sram_addr", sram_address, 32'hC00);
        @(negedge clk);
        #1;
        rst = 1;
        #1;
        chk("t6_rst_sram_rd", 32'(sram_read_en), 32'd0);
        chk("t6_rst_fill", 32'(cache_write_en), 32'd0);
        mem_r_en = 0;
        #1;
        chk("t6_rst_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 0;
        lat = 3;
        do_req(1, 0, 32'h800, 0, 32'hD000_0200);
        chk("t6_idle_hit", stalls, 0);
        chk("t6_no_fill", fills, 0);
        @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
